// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : control FSM states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Purely combinational one-bit full adder used by serial_adder for the
// per-cycle add.
// Ports:
//   a, b : input operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    // Propagate term shared by sum and carry.
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: {cout,S} = X + Y + cin, one bit per clock, LSB first.
// An operation takes WIDTH SHIFT cycles plus one DONE cycle.
// Ports:
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   start    : load request, honoured only while in_ready=1
//   X, Y     : operands, sampled on the accepted start edge
//   cin      : carry in, sampled on the accepted start edge
//   in_ready : high in IDLE
//   busy     : high in SHIFT
//   done     : one-cycle pulse in DONE
//   S        : registered sum of the last completed operation
//   cout     : registered carry-out of the last completed operation
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_psum_next;
    logic             w_last;

    full_adder u_full_adder (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first bit
    // produced has travelled down to bit 0.
    assign w_psum_next = WIDTH'({w_sum, r_psum} >> 1);
    assign w_last      = (r_cnt == LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= X;
                        r_b     <= Y;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_psum  <= w_psum_next;
                    if (w_last) begin
                        // Final bit: publish result; counter holds so it
                        // never wraps inside an operation.
                        r_s    <= w_psum_next;
                        r_cout <= w_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S    = r_s;
    assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         cin;
    logic         in_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         cout;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .X        (X),
        .Y        (Y),
        .cin      (cin),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .S        (S),
        .cout     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the sample point right after an accepted operation edge
    // (or later, with exp_lat reduced accordingly). Waits for done, checks
    // busy duration, latency, result, and the single-cycle done pulse.
    task automatic wait_result(input string tag, input int exp_lat, input logic [8:0] exp_sum);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            tick;
            n++;
        end
        check({tag, " busy_cycles"}, nb, exp_lat);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " done"}, {31'b0, done}, 1);
        check({tag, " sum"}, {23'b0, cout, S}, {23'b0, exp_sum});
        tick;
        check({tag, " done_pulse_end"}, {31'b0, done}, 0);
        check({tag, " in_ready_back"}, {31'b0, in_ready}, 1);
        $display("op %s: cout=%0d S=0x%02h latency=%0d", tag, cout, S, n);
    endtask

    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic [8:0] exp_sum);
        X     = x;
        Y     = y;
        cin   = c;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_result(tag, 8, exp_sum);
    endtask

    initial begin
        logic [8:0] prev_result;
        logic [8:0] exp;
        logic [7:0] rx;
        logic [7:0] ry;
        logic       rc;
        int         g;
        int         n;
        int         ndone;
        int         prev_done;

        rst_n = 1'b0;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        cin   = 1'b0;

        // Reset state
        repeat (3) tick;
        check("rst in_ready", {31'b0, in_ready}, 1);
        check("rst busy", {31'b0, busy}, 0);
        check("rst done", {31'b0, done}, 0);
        check("rst sum", {23'b0, cout, S}, 0);
        rst_n = 1'b1;
        check("post_rst in_ready", {31'b0, in_ready}, 1);
        tick;
        check("post_rst in_ready_1", {31'b0, in_ready}, 1);

        // Directed operations
        run_op("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("7f+01", 8'h7F, 8'h01, 1'b0, 9'h080);
        run_op("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 9'h100);

        // Result holds through idle cycles, even with operands moving
        for (int i = 0; i < 10; i++) begin
            X = 8'(i * 37);
            Y = 8'(i * 11);
            tick;
            check("hold sum", {23'b0, cout, S}, 9'h100);
        end

        // start during SHIFT is ignored
        X     = 8'h12;
        Y     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        X     = 8'hFF;
        Y     = 8'hFF;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("midshift busy", {31'b0, busy}, 1);
        check("midshift sum_held", {23'b0, cout, S}, 9'h100);
        wait_result("ignore_start", 5, 9'h046);

        // Asynchronous reset in the middle of SHIFT
        X     = 8'hFF;
        Y     = 8'hFF;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst in_ready", {31'b0, in_ready}, 1);
        check("async_rst busy", {31'b0, busy}, 0);
        check("async_rst sum", {23'b0, cout, S}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) ndone++;
        end
        check("async_rst no_done", ndone, 0);
        check("async_rst sum_held", {23'b0, cout, S}, 0);
        run_op("03+04", 8'h03, 8'h04, 1'b0, 9'h007);

        // Back-to-back with start held high
        start     = 1'b1;
        prev_done = 0;
        for (int i = 0; i < 50; i++) begin
            g = 0;
            while (!in_ready && g < 30) begin
                tick;
                g++;
            end
            rx  = 8'($urandom);
            ry  = 8'($urandom);
            rc  = 1'($urandom);
            X   = rx;
            Y   = ry;
            cin = rc;
            exp = {1'b0, rx} + {1'b0, ry} + {8'b0, rc};
            tick;
            n = 0;
            while (!done && n < 40) begin
                tick;
                n++;
            end
            check("b2b done", {31'b0, done}, 1);
            check("b2b sum", {23'b0, cout, S}, {23'b0, exp});
            if (i > 0) check("b2b period", cyc - prev_done, 10);
            $display("b2b %0d: X=0x%02h Y=0x%02h cin=%0d -> cout=%0d S=0x%02h", i, rx, ry, rc, cout, S);
            prev_done = cyc;
            if (i == 49) start = 1'b0;
            tick;
        end
        prev_result = {cout, S};
        repeat (3) tick;
        check("final idle", {31'b0, in_ready}, 1);
        check("final hold", {23'b0, cout, S}, {23'b0, prev_result});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to load operands; honoured only while in_ready=1.
REQ-005 X  input  WIDTH  operand A, sampled on the accepted start edge.
REQ-006 Y  input  WIDTH  operand B, sampled on the accepted start edge.
REQ-007 cin  input  1  carry-in, sampled on the accepted start edge.
REQ-008 in_ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high only in SHIFT.
REQ-010 done  output  1  single-cycle pulse, high only in DONE.
REQ-011 S  output  WIDTH  registered sum of the last completed operation.
REQ-012 cout  output  1  registered carry-out of the last completed operation.

Function
REQ-013 FSM states IDLE, SHIFT, DONE, each decoded one-to-one onto in_ready, busy and done respectively.
REQ-014 IDLE, start=1 at an edge: load X and Y into shift registers, load cin into carry flop, clear bit counter, enter SHIFT.
REQ-015 IDLE, start=0: remain in IDLE; shift registers, S and cout unchanged.
REQ-016 SHIFT, each edge: full-add LSB(A), LSB(B), carry; shift the sum bit into the partial-sum register MSB, shifting right; shift A and B right by one; carry flop takes the carry output; counter increments.
REQ-017 SHIFT lasts exactly WIDTH edges; on the edge where the counter reaches WIDTH-1, copy the partial sum to S and the carry to cout, and enter DONE.
REQ-018 DONE lasts exactly one cycle, then returns unconditionally to IDLE.
REQ-019 Latency: start accepted at edge k -> done high between edges k+WIDTH and k+WIDTH+1; in_ready high again after edge k+WIDTH+1.
REQ-020 start while in SHIFT or DONE is ignored; it does not queue, restart, or alter the operation in progress.
REQ-021 S and cout change only on the edge entering DONE, or on reset, and hold between operations.
REQ-022 Result is exact modulo 2^(WIDTH+1): {cout,S} = X + Y + cin.
REQ-023 Bit counter width is clog2(WIDTH); it does not wrap within one operation.
REQ-024 Back-to-back operation: start held high continuously produces one operation every WIDTH+2 cycles.

Reset
REQ-025 rst_n low asynchronously forces IDLE, clears S, cout, carry flop, shift registers and counter, and deasserts busy and done.
REQ-026 Reset asserted during SHIFT aborts the operation with no done pulse and no update of S or cout beyond the clear in REQ-025.
REQ-027 After rst_n deasserts, in_ready=1 starting with the first cycle.

Structure
REQ-028 Package serial_adder_pkg holds the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 One sub-module full_adder (ports a, b, ci -> s, co) performs the per-bit add; it is purely combinational. All registers reside in serial_adder.

Verification (WIDTH=8)
REQ-030 Reset, then X=0x00, Y=0x00, cin=0, start for one cycle -> busy high for 8 cycles, done pulse 9 cycles after start, S=0x00, cout=0.
REQ-031 X=0xFF, Y=0x01, cin=0 -> S=0x00, cout=1; X=0x7F, Y=0x01, cin=0 -> S=0x80, cout=0.
REQ-032 X=0xA5, Y=0x5A, cin=1 -> S=0x00, cout=1; S and cout held unchanged for 10 idle cycles afterwards.
REQ-033 X=0x12, Y=0x34 accepted; at cycle 3 of SHIFT, start pulses with X=0xFF, Y=0xFF -> the pulse is ignored and the result is S=0x46, cout=0.
REQ-034 Operation started with X=0xFF, Y=0xFF; rst_n pulses low asynchronously mid-SHIFT -> IDLE immediately, S=0x00, cout=0, no done pulse; the next operation 0x03+0x04 yields S=0x07.
REQ-035 start held high with random operands for 50 operations -> done period is exactly 10 cycles and every {cout,S} matches the X+Y+cin reference model.
